// File: rtl/load_store_unit_if.sv
// Bundles the EX-side request channel, the data-memory bus and the
// writeback/exception outputs of the load/store unit.
// The unit connects through the slave modport.
// The pipeline/memory side (or a testbench) connects through the master modport.
interface load_store_unit_if;
    // request from EX
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    // data-memory bus
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    // writeback / exception / status
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [2:0]  exc_cause;
    logic [31:0] exc_addr;
    logic        busy;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output req_ready, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        output wb_valid, wb_rd, wb_data, exc_valid, exc_cause, exc_addr, busy
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  req_ready, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        input  wb_valid, wb_rd, wb_data, exc_valid, exc_cause, exc_addr, busy
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory stage behind the ALU.
// Accepts one load/store at a time and runs it as a single data-memory
// transaction. Load data comes back aligned and extended for writeback.
// Misaligned accesses, illegal funct3 codes and bus timeouts are reported
// as one-cycle exception pulses.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_EXC  = 3'd4;

    localparam logic [2:0] CAUSE_LOAD_MISALIGN  = 3'd1;
    localparam logic [2:0] CAUSE_STORE_MISALIGN = 3'd2;
    localparam logic [2:0] CAUSE_ILLEGAL        = 3'd3;
    localparam logic [2:0] CAUSE_TIMEOUT        = 3'd4;

    localparam bit TIMEOUT_EN = (TIMEOUT != 0);
    localparam int CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;

    // captured request
    logic             cap_we;
    logic [2:0]       cap_funct3;
    logic [31:0]      cap_addr;
    logic [4:0]       cap_rd;

    // registered bus and result outputs
    logic [31:0]      mem_addr_q;
    logic             mem_we_q;
    logic [3:0]       mem_wstrb_q;
    logic [31:0]      mem_wdata_q;
    logic [4:0]       wb_rd_q;
    logic [31:0]      wb_data_q;
    logic [2:0]       exc_cause_q;
    logic [31:0]      exc_addr_q;

    // decode of the incoming request
    logic             dec_illegal;
    logic             dec_misaligned;
    logic [2:0]       dec_cause;
    logic [3:0]       dec_wstrb;
    logic [31:0]      dec_wdata;

    // load extraction
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;

    // transition conditions
    logic             accept;
    logic             accept_fault;
    logic             accept_ok;
    logic             mem_handshake;
    logic             rsp_taken;
    logic             timeout_hit;

    assign accept        = (state == S_IDLE) && bus.req_valid;
    assign accept_fault  = accept && (dec_illegal || dec_misaligned);
    assign accept_ok     = accept && !(dec_illegal || dec_misaligned);
    assign mem_handshake = (state == S_REQ) && bus.mem_req_ready;
    assign rsp_taken     = (state == S_WAIT) && bus.mem_rsp_valid;
    assign timeout_hit   = TIMEOUT_EN && (state == S_WAIT) && !bus.mem_rsp_valid
                           && (cnt == CNT_LAST);

    // Classify the presented request and build its strobes and lane-replicated data.
    always_comb begin
        dec_illegal    = 1'b0;
        dec_misaligned = 1'b0;
        dec_cause      = CAUSE_ILLEGAL;
        dec_wstrb      = 4'b0000;
        dec_wdata      = 32'h0;
        case (bus.req_funct3)
            3'b000, 3'b100: dec_misaligned = 1'b0;
            3'b001, 3'b101: dec_misaligned = bus.req_addr[0];
            3'b010:         dec_misaligned = (bus.req_addr[1:0] != 2'b00);
            default:        dec_illegal    = 1'b1;
        endcase
        if (bus.req_we && bus.req_funct3[2]) begin
            dec_illegal = 1'b1;
        end
        if (!dec_illegal) begin
            dec_cause = bus.req_we ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
        end
        if (bus.req_we) begin
            case (bus.req_funct3[1:0])
                2'b00: begin
                    dec_wstrb = 4'b0001 << bus.req_addr[1:0];
                    dec_wdata = {4{bus.req_wdata[7:0]}};
                end
                2'b01: begin
                    dec_wstrb = 4'b0011 << {bus.req_addr[1], 1'b0};
                    dec_wdata = {2{bus.req_wdata[15:0]}};
                end
                default: begin
                    dec_wstrb = 4'b1111;
                    dec_wdata = bus.req_wdata;
                end
            endcase
        end
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        ld_byte = 8'h0;
        case (cap_addr[1:0])
            2'd0: ld_byte = bus.mem_rdata[7:0];
            2'd1: ld_byte = bus.mem_rdata[15:8];
            2'd2: ld_byte = bus.mem_rdata[23:16];
            default: ld_byte = bus.mem_rdata[31:24];
        endcase
        ld_half = cap_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (cap_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = bus.mem_rdata;
        endcase
    end

    // Main control FSM and WAIT-state timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_fault) begin
                        state <= S_EXC;
                    end else if (accept_ok) begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_handshake) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        state <= cap_we ? S_IDLE : S_DONE;
                    end else if (timeout_hit) begin
                        state <= S_EXC;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_EXC:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Capture the request fields at acceptance; they stay valid for the whole transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_we     <= 1'b0;
            cap_funct3 <= 3'b000;
            cap_addr   <= 32'h0;
            cap_rd     <= 5'd0;
        end else if (accept) begin
            cap_we     <= bus.req_we;
            cap_funct3 <= bus.req_funct3;
            cap_addr   <= bus.req_addr;
            cap_rd     <= bus.req_rd;
        end
    end

    // Memory request fields are registered at acceptance so they stay stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q  <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else if (accept_ok) begin
            mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
            mem_we_q    <= bus.req_we;
            mem_wstrb_q <= dec_wstrb;
            mem_wdata_q <= dec_wdata;
        end
    end

    // Load result is registered on entry to DONE and held afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_rd_q   <= 5'd0;
            wb_data_q <= 32'h0;
        end else if (rsp_taken && !cap_we) begin
            wb_rd_q   <= cap_rd;
            wb_data_q <= ld_data;
        end
    end

    // Exception record, loaded from decode faults or from a WAIT timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_cause_q <= 3'd0;
            exc_addr_q  <= 32'h0;
        end else if (accept_fault) begin
            exc_cause_q <= dec_cause;
            exc_addr_q  <= bus.req_addr;
        end else if (timeout_hit) begin
            exc_cause_q <= CAUSE_TIMEOUT;
            exc_addr_q  <= cap_addr;
        end
    end

    assign bus.req_ready     = (state == S_IDLE);
    assign bus.busy          = (state != S_IDLE);
    assign bus.mem_req_valid = (state == S_REQ);
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_wstrb     = mem_wstrb_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.wb_valid      = (state == S_DONE);
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.exc_valid     = (state == S_EXC);
    assign bus.exc_cause     = exc_cause_q;
    assign bus.exc_addr      = exc_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (TIMEOUT=4).
// Table-driven single transactions are followed by hand-written multi-cycle
// sequences: backpressure, latency, timeout and reset.
module tb_load_store_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        exp_exc;
        logic [2:0]  exp_cause;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_mem_addr;
        logic [31:0] exp_mem_wdata;
        logic [31:0] exp_wb_data;
    } vec_t;

    vec_t vecs[$];

    // free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic add_vec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd,
                           input logic [31:0] rdata, input logic exc, input logic [2:0] cause,
                           input logic [3:0] wstrb, input logic [31:0] maddr,
                           input logic [31:0] mwdata, input logic [31:0] wbdata);
        vec_t v;
        v.we = we; v.funct3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.rdata = rdata; v.exp_exc = exc; v.exp_cause = cause; v.exp_wstrb = wstrb;
        v.exp_mem_addr = maddr; v.exp_mem_wdata = mwdata; v.exp_wb_data = wbdata;
        vecs.push_back(v);
    endtask

    task automatic present_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] rd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_rd     = rd;
    endtask

    // Runs one table vector from an idle unit; all sampling happens on falling edges.
    task automatic apply_stimulus(input int i);
        vec_t v;
        v = vecs[i];
        @(negedge clk);
        check_output($sformatf("v%0d req_ready", i), 32'(bus.req_ready), 32'd1);
        present_req(v.we, v.funct3, v.addr, v.wdata, v.rd);
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (v.exp_exc) begin
            check_output($sformatf("v%0d exc_valid", i), 32'(bus.exc_valid), 32'd1);
            check_output($sformatf("v%0d exc_cause", i), 32'(bus.exc_cause), 32'(v.exp_cause));
            check_output($sformatf("v%0d exc_addr", i), bus.exc_addr, v.addr);
            check_output($sformatf("v%0d mem_req_valid", i), 32'(bus.mem_req_valid), 32'd0);
            @(negedge clk);
            check_output($sformatf("v%0d exc_pulse", i), 32'(bus.exc_valid), 32'd0);
            check_output($sformatf("v%0d ready_after_exc", i), 32'(bus.req_ready), 32'd1);
        end else begin
            check_output($sformatf("v%0d mem_req_valid", i), 32'(bus.mem_req_valid), 32'd1);
            check_output($sformatf("v%0d mem_addr", i), bus.mem_addr, v.exp_mem_addr);
            check_output($sformatf("v%0d mem_we", i), 32'(bus.mem_we), 32'(v.we));
            check_output($sformatf("v%0d mem_wstrb", i), 32'(bus.mem_wstrb), 32'(v.exp_wstrb));
            if (v.we) begin
                check_output($sformatf("v%0d mem_wdata", i), bus.mem_wdata, v.exp_mem_wdata);
            end
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            check_output($sformatf("v%0d mem_req_drop", i), 32'(bus.mem_req_valid), 32'd0);
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rdata     = v.rdata;
            @(negedge clk);
            bus.mem_rsp_valid = 1'b0;
            check_output($sformatf("v%0d exc_quiet", i), 32'(bus.exc_valid), 32'd0);
            if (!v.we) begin
                check_output($sformatf("v%0d wb_valid", i), 32'(bus.wb_valid), 32'd1);
                check_output($sformatf("v%0d wb_data", i), bus.wb_data, v.exp_wb_data);
                check_output($sformatf("v%0d wb_rd", i), 32'(bus.wb_rd), 32'(v.rd));
                @(negedge clk);
                check_output($sformatf("v%0d wb_pulse", i), 32'(bus.wb_valid), 32'd0);
            end else begin
                check_output($sformatf("v%0d store_no_wb", i), 32'(bus.wb_valid), 32'd0);
                check_output($sformatf("v%0d store_idle", i), 32'(bus.req_ready), 32'd1);
            end
        end
    endtask

    // drives an accepted request through the memory handshake, leaving the unit in WAIT
    task automatic start_in_wait(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [4:0] rd);
        @(negedge clk);
        present_req(we, f3, addr, 32'h0, rd);
        @(negedge clk);
        bus.req_valid     = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.req_rd = 5'd0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rdata = 32'h0;

        //        we  f3      addr          wdata         rd     rdata         exc cause wstrb  mem_addr      mem_wdata     wb_data
        add_vec(0, 3'b000, 32'h0000_1003, 32'h0,        5'd5,  32'h80FF_7F01, 0, 3'd0, 4'h0, 32'h0000_1000, 32'h0,        32'hFFFF_FF80);
        add_vec(0, 3'b100, 32'h0000_1003, 32'h0,        5'd6,  32'h80FF_7F01, 0, 3'd0, 4'h0, 32'h0000_1000, 32'h0,        32'h0000_0080);
        add_vec(0, 3'b001, 32'h0000_1002, 32'h0,        5'd7,  32'h80FF_7F01, 0, 3'd0, 4'h0, 32'h0000_1000, 32'h0,        32'hFFFF_80FF);
        add_vec(0, 3'b101, 32'h0000_1000, 32'h0,        5'd8,  32'h80FF_7F01, 0, 3'd0, 4'h0, 32'h0000_1000, 32'h0,        32'h0000_7F01);
        add_vec(0, 3'b010, 32'h0000_1004, 32'h0,        5'd31, 32'hDEAD_BEEF, 0, 3'd0, 4'h0, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF);
        add_vec(0, 3'b000, 32'h0000_1001, 32'h0,        5'd1,  32'h80FF_7F01, 0, 3'd0, 4'h0, 32'h0000_1000, 32'h0,        32'h0000_007F);
        add_vec(0, 3'b101, 32'h0000_1002, 32'h0,        5'd2,  32'h80FF_7F01, 0, 3'd0, 4'h0, 32'h0000_1000, 32'h0,        32'h0000_80FF);
        add_vec(0, 3'b000, 32'h0000_1002, 32'h0,        5'd3,  32'h80FF_7F01, 0, 3'd0, 4'h0, 32'h0000_1000, 32'h0,        32'hFFFF_FFFF);
        add_vec(1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd0, 32'h0,         0, 3'd0, 4'hC, 32'h0000_2000, 32'hABCD_ABCD, 32'h0);
        add_vec(1, 3'b000, 32'h0000_2001, 32'h0000_00EF, 5'd0, 32'h0,         0, 3'd0, 4'h2, 32'h0000_2000, 32'hEFEF_EFEF, 32'h0);
        add_vec(1, 3'b010, 32'h0000_2008, 32'hCAFE_F00D, 5'd0, 32'h0,         0, 3'd0, 4'hF, 32'h0000_2008, 32'hCAFE_F00D, 32'h0);
        add_vec(1, 3'b000, 32'h0000_2003, 32'h1234_5678, 5'd0, 32'h0,         0, 3'd0, 4'h8, 32'h0000_2000, 32'h7878_7878, 32'h0);
        add_vec(1, 3'b001, 32'h0000_2000, 32'hAAAA_5566, 5'd0, 32'h0,         0, 3'd0, 4'h3, 32'h0000_2000, 32'h5566_5566, 32'h0);
        add_vec(0, 3'b010, 32'h0000_3002, 32'h0,        5'd4,  32'h0,         1, 3'd1, 4'h0, 32'h0,         32'h0,        32'h0);
        add_vec(1, 3'b001, 32'h0000_3001, 32'h0,        5'd0,  32'h0,         1, 3'd2, 4'h0, 32'h0,         32'h0,        32'h0);
        add_vec(0, 3'b011, 32'h0000_3000, 32'h0,        5'd4,  32'h0,         1, 3'd3, 4'h0, 32'h0,         32'h0,        32'h0);
        add_vec(1, 3'b100, 32'h0000_3004, 32'h0,        5'd0,  32'h0,         1, 3'd3, 4'h0, 32'h0,         32'h0,        32'h0);
        add_vec(0, 3'b001, 32'h0000_3003, 32'h0,        5'd4,  32'h0,         1, 3'd1, 4'h0, 32'h0,         32'h0,        32'h0);
        add_vec(1, 3'b010, 32'h0000_3006, 32'h0,        5'd0,  32'h0,         1, 3'd2, 4'h0, 32'h0,         32'h0,        32'h0);
        add_vec(0, 3'b111, 32'h0000_3001, 32'h0,        5'd4,  32'h0,         1, 3'd3, 4'h0, 32'h0,         32'h0,        32'h0);

        // reset state
        #12;
        check_output("rst req_ready", 32'(bus.req_ready), 32'd1);
        check_output("rst busy", 32'(bus.busy), 32'd0);
        check_output("rst mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check_output("rst wb_valid", 32'(bus.wb_valid), 32'd0);
        check_output("rst exc_valid", 32'(bus.exc_valid), 32'd0);
        check_output("rst mem_addr", bus.mem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(i);
        end

        // backpressure: mem_* stay put while the request inputs change and a stray response arrives
        @(negedge clk);
        present_req(1'b1, 3'b010, 32'h0000_4000, 32'h1122_3344, 5'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'h0;
        for (int k = 0; k < 5; k++) begin
            check_output($sformatf("bp%0d mem_req_valid", k), 32'(bus.mem_req_valid), 32'd1);
            check_output($sformatf("bp%0d mem_addr", k), bus.mem_addr, 32'h0000_4000);
            check_output($sformatf("bp%0d mem_wstrb", k), 32'(bus.mem_wstrb), 32'hF);
            check_output($sformatf("bp%0d mem_wdata", k), bus.mem_wdata, 32'h1122_3344);
            check_output($sformatf("bp%0d busy", k), 32'(bus.busy), 32'd1);
            check_output($sformatf("bp%0d req_ready", k), 32'(bus.req_ready), 32'd0);
            bus.mem_rsp_valid = (k == 2);
            @(negedge clk);
        end
        bus.mem_rsp_valid = 1'b0;
        check_output("bp still_req", 32'(bus.mem_req_valid), 32'd1);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        check_output("bp wait_busy", 32'(bus.busy), 32'd1);
        bus.mem_rsp_valid = 1'b1;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        check_output("bp store_idle", 32'(bus.busy), 32'd0);
        check_output("bp store_no_wb", 32'(bus.wb_valid), 32'd0);

        // zero-wait LW, then back-to-back request on the first edge with req_ready=1
        @(negedge clk);
        present_req(1'b0, 3'b010, 32'h0000_6000, 32'h0, 5'd9);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        check_output("lat wb_valid", 32'(bus.wb_valid), 32'd1);
        check_output("lat wb_data", bus.wb_data, 32'hDEAD_BEEF);
        check_output("lat wb_rd", 32'(bus.wb_rd), 32'd9);
        check_output("lat ready_in_done", 32'(bus.req_ready), 32'd0);
        present_req(1'b0, 3'b001, 32'h0000_6001, 32'h0, 5'd10);
        @(negedge clk);
        check_output("lat wb_pulse", 32'(bus.wb_valid), 32'd0);
        check_output("lat ready_again", 32'(bus.req_ready), 32'd1);
        check_output("lat not_yet_taken", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_output("lat b2b exc_valid", 32'(bus.exc_valid), 32'd1);
        check_output("lat b2b exc_cause", 32'(bus.exc_cause), 32'd1);
        check_output("lat b2b exc_addr", bus.exc_addr, 32'h0000_6001);
        @(negedge clk);

        // timeout: no response, exception on the 4th WAIT edge
        start_in_wait(1'b0, 3'b010, 32'h0000_5000, 5'd11);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check_output($sformatf("to edge%0d exc_valid", k), 32'(bus.exc_valid), 32'd0);
            check_output($sformatf("to edge%0d busy", k), 32'(bus.busy), 32'd1);
        end
        @(negedge clk);
        check_output("to exc_valid", 32'(bus.exc_valid), 32'd1);
        check_output("to exc_cause", 32'(bus.exc_cause), 32'd4);
        check_output("to exc_addr", bus.exc_addr, 32'h0000_5000);
        check_output("to no_wb", 32'(bus.wb_valid), 32'd0);
        @(negedge clk);
        check_output("to exc_pulse", 32'(bus.exc_valid), 32'd0);
        check_output("to idle", 32'(bus.busy), 32'd0);

        // response on the same edge as the timeout wins
        start_in_wait(1'b0, 3'b010, 32'h0000_5004, 5'd3);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'hA5A5_1234;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        check_output("race wb_valid", 32'(bus.wb_valid), 32'd1);
        check_output("race exc_valid", 32'(bus.exc_valid), 32'd0);
        check_output("race wb_data", bus.wb_data, 32'hA5A5_1234);
        @(negedge clk);
        check_output("race after exc_valid", 32'(bus.exc_valid), 32'd0);

        // reset during WAIT abandons the transaction
        start_in_wait(1'b0, 3'b000, 32'h0000_7000, 5'd4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("mid_rst mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check_output("mid_rst req_ready", 32'(bus.req_ready), 32'd1);
        check_output("mid_rst busy", 32'(bus.busy), 32'd0);
        check_output("mid_rst wb_data", bus.wb_data, 32'h0);
        check_output("mid_rst exc_cause", 32'(bus.exc_cause), 32'd0);
        check_output("mid_rst mem_addr", bus.mem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h1111_2222;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        check_output("stray wb_valid", 32'(bus.wb_valid), 32'd0);
        check_output("stray busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check_output("stray wb_valid_late", 32'(bus.wb_valid), 32'd0);
        check_output("stray wb_data", bus.wb_data, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage that sits directly downstream of the ALU.
- Takes the ALU result as the effective address, plus rs2 data and funct3.
- Runs one data-memory transaction over a valid/ready request channel and a response-valid channel.
- Returns aligned, sign- or zero-extended load data to writeback, and flags misaligned, illegal or timed-out accesses as exceptions.

Parameters:
TIMEOUT, 16, number of WAIT-state clock edges with no mem_rsp_valid before a bus-timeout exception; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  memory op presented by EX
req_ready  out  1  unit can accept; equals (state==IDLE), combinational
req_we  in  1  1=store, 0=load
req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
req_addr  in  32  effective address (ALU result)
req_wdata  in  32  store data (rs2)
req_rd  in  5  load destination register
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  32  word-aligned address {req_addr[31:2],2'b00}
mem_we  out  1  write enable
mem_wstrb  out  4  byte strobes (0000 for loads)
mem_wdata  out  32  lane-replicated store data
mem_rsp_valid  in  1  response/ack, one cycle
mem_rdata  in  32  load word
wb_valid  out  1  one-cycle pulse, load data ready
wb_rd  out  5  destination register
wb_data  out  32  extended load data
exc_valid  out  1  one-cycle exception pulse
exc_cause  out  3  1 load misaligned, 2 store misaligned, 3 illegal funct3, 4 bus timeout
exc_addr  out  32  faulting req_addr
busy  out  1  state!=IDLE

Behaviour:
- Reset (async) forces state IDLE. All outputs are 0 except req_ready=1. The timeout counter is 0.
- States: IDLE, REQ, WAIT, DONE, EXC.
- IDLE: request is accepted at edge E0 when req_valid&&req_ready. All req_* fields are captured in registers. Decode happens at acceptance:
  - Illegal: funct3 in {011,110,111}, or a store with funct3[2]=1. Next state EXC, cause 3.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0. Next state EXC, cause 1 (load) or 2 (store). No memory access is issued.
  - Otherwise: next state REQ.
- REQ:
  - mem_req_valid=1. mem_addr, mem_we, mem_wstrb and mem_wdata are registered and held stable until handshake.
  - On mem_req_valid&&mem_req_ready at an edge: go to WAIT and clear the counter.
  - mem_rsp_valid is ignored in REQ.
- Store strobes and data:
  - SB: wstrb=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: wstrb=0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}.
  - SW: wstrb=1111, wdata=wdata.
- WAIT, evaluated at each edge in this priority order:
  - mem_rsp_valid: load → DONE; store → IDLE.
  - Else if TIMEOUT!=0 and cnt==TIMEOUT-1 → EXC, cause 4.
  - Else cnt++.
  - A response arriving on the same edge as the timeout wins.
- Load extraction from mem_rdata, registered into wb_data on entry to DONE:
  - B/BU: byte lane addr[1:0], sign-/zero-extended.
  - H/HU: half lane addr[1], sign-/zero-extended.
  - W: whole word.
- DONE: wb_valid=1 and wb_rd=captured rd for exactly one cycle, then IDLE.
- EXC: exc_valid=1 with exc_cause and exc_addr for exactly one cycle, then IDLE.
- Latencies:
  - Minimum load: accept E0, handshake E1, response E2, wb_valid high in the cycle after E2, req_ready high again after E3.
  - Minimum store: IDLE after E2.
- Back-to-back: a new request may be accepted on the first edge where req_ready=1. No skid buffer.
- Outside DONE/EXC: wb_valid=0 and exc_valid=0. wb_data and exc_* hold their last values.
- Reset mid-transaction: the transaction is abandoned and mem_req_valid drops immediately. A later stray mem_rsp_valid is ignored in IDLE.
- mem_rsp_valid while in IDLE, DONE or EXC is ignored.

Test Plan:
1. Load path with sign extension:
   - LB at addr 0x1003, mem_rdata=0x80FF7F01 → mem_addr=0x1000, wstrb=0000, wb_data=0xFFFFFF80, wb_rd=captured rd.
   - LBU on the same data → wb_data=0x00000080.
2. Store strobes:
   - SH addr 0x2002, wdata=0x1234ABCD → mem_wstrb=1100, mem_wdata=0xABCDABCD, mem_we=1.
   - SB addr 0x2001, wdata=0xEF → wstrb=0010, wdata=0xEFEFEFEF.
   - Store response → IDLE with no wb_valid.
3. Misaligned and illegal:
   - LW addr 0x3002 → exc_valid pulse, cause 1, exc_addr=0x3002, mem_req_valid never asserted.
   - SH addr 0x3001 → cause 2.
   - Load funct3=011 → cause 3.
4. Backpressure and latency:
   - Hold mem_req_ready=0 for 5 cycles → mem_* stable throughout, busy=1, req_ready=0.
   - Zero-wait LW of 0xDEADBEEF → wb_valid 3 edges after accept, next request accepted on the following edge.
5. Timeout with TIMEOUT=4:
   - No response → cause 4 on the 4th WAIT edge.
   - Response on the 4th edge → normal wb_valid, no exception.
6. Reset mid-transaction:
   - Assert rst during WAIT → all outputs 0 immediately, req_ready=1.
   - Subsequent mem_rsp_valid produces no wb_valid.
